// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port synchronous RAM between
// the instruction-fetch port (0) and the data load/store port (1). One
// transaction is in flight at a time. Every output comes straight from a flop.
module mem_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   // port 0 : instruction fetch
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   // port 1 : data load/store
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   // unified RAM
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // The latency counter is 3 bits, so only 1..7 cycles can be timed.
   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
      $error("mem_arbiter: MEM_LAT=%0d is outside 1..7", MEM_LAT);
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        r_state;
   logic          r_last_grant;   // port that won the previous transaction
   logic          r_winner;       // port owning the current transaction
   logic          r_we;           // current transaction is a write
   logic [2:0]    r_cnt;          // RAM read latency countdown

   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;

   logic          w_pick1;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;

   // Winner selection: a lone request wins, a tie goes to the port that did
   // not win last time.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves
      // one unassigned and no latch is inferred.
      w_pick1 = 1'b0;
      w_we    = we0;
      w_addr  = addr0;
      w_wdata = wdata0;
      if (req1 && (!req0 || (r_last_grant == 1'b0))) begin
         w_pick1 = 1'b1;
         w_we    = we1;
         w_addr  = addr1;
         w_wdata = wdata1;
      end
   end

   // Transaction FSM; outputs are registered alongside the state so each pulse
   // lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_winner     <= 1'b0;
         r_we         <= 1'b0;
         r_cnt        <= 3'd0;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_rvalid0    <= 1'b0;
         r_rvalid1    <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every flop samples the
         // pre-edge values regardless of statement order.
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (req0 || req1) begin
                  r_winner    <= w_pick1;
                  r_we        <= w_we;
                  // Issue-cycle outputs are loaded now so they appear in ISSUE.
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= w_we;
                  r_mem_addr  <= w_addr;
                  r_mem_wdata <= w_wdata;
                  r_gnt0      <= ~w_pick1;
                  r_gnt1      <= w_pick1;
                  r_state     <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               r_last_grant <= r_winner;
               if (r_we) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt   <= 3'(MEM_LAT);
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  if (r_winner) begin
                     r_rdata1  <= mem_rdata;
                     r_rvalid1 <= 1'b1;
                  end else begin
                     r_rdata0  <= mem_rdata;
                     r_rvalid0 <= 1'b1;
                  end
                  r_state <= S_RESP;
               end
            end

            S_RESP: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign rvalid0   = r_rvalid0;
   assign rvalid1   = r_rvalid1;
   assign rdata0    = r_rdata0;
   assign rdata1    = r_rdata1;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus for mem_arbiter with
// MEM_LAT=1 (u_lat1) and MEM_LAT=3 (u_lat3), each driving its own RAM model.
module tb_mem_arbiter;

   logic clk;
   logic reset;

   // ---------------- MEM_LAT = 1 instance ----------------
   logic        req0, we0, gnt0, rvalid0;
   logic [7:0]  addr0;
   logic [31:0] wdata0, rdata0;
   logic        req1, we1, gnt1, rvalid1;
   logic [7:0]  addr1;
   logic [31:0] wdata1, rdata1;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   // ---------------- MEM_LAT = 3 instance (port 0 only) ----------------
   logic        l3_req0, l3_we0, l3_gnt0, l3_rvalid0;
   logic [7:0]  l3_addr0;
   logic [31:0] l3_wdata0, l3_rdata0;
   logic        l3_gnt1, l3_rvalid1;
   logic [31:0] l3_rdata1;
   logic        l3_mem_en, l3_mem_we;
   logic [7:0]  l3_mem_addr;
   logic [31:0] l3_mem_wdata, l3_mem_rdata;

   mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.AW(8), .DW(32), .MEM_LAT(3)) u_lat3 (
      .clk(clk), .reset(reset),
      .req0(l3_req0), .we0(l3_we0), .addr0(l3_addr0), .wdata0(l3_wdata0),
      .gnt0(l3_gnt0), .rvalid0(l3_rvalid0), .rdata0(l3_rdata0),
      .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(32'h0),
      .gnt1(l3_gnt1), .rvalid1(l3_rvalid1), .rdata1(l3_rdata1),
      .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
      .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-on RAM contents; 0x10 holds the single-read test word.
   function automatic logic [31:0] init_val(input int a);
      if (a == 'h10) return 32'hDEADBEEF;
      return {8'(a), 8'(~a), 8'(a ^ 'h5a), 8'h3c};
   endfunction

   // RAM model, 1-cycle read latency; reloaded while reset is high.
   logic [31:0] ram1 [0:255];
   logic [31:0] ram1_q;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) ram1[i] <= init_val(i);
      end else if (mem_en && mem_we) begin
         ram1[mem_addr] <= mem_wdata;
      end
      if (mem_en && !mem_we) ram1_q <= ram1[mem_addr];
   end
   assign mem_rdata = ram1_q;

   // RAM model, 3-cycle read latency.
   logic [31:0] ram3 [0:255];
   logic [31:0] ram3_q0, ram3_q1, ram3_q2;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) ram3[i] <= init_val(i);
      end else if (l3_mem_en && l3_mem_we) begin
         ram3[l3_mem_addr] <= l3_mem_wdata;
      end
      if (l3_mem_en && !l3_mem_we) ram3_q0 <= ram3[l3_mem_addr];
      ram3_q1 <= ram3_q0;
      ram3_q2 <= ram3_q1;
   end
   assign l3_mem_rdata = ram3_q2;

   // Protocol monitor: mutual exclusion and mem_en only alongside a grant.
   int viol = 0;
   always @(negedge clk) begin
      if (gnt0 && gnt1)                         viol++;
      if (rvalid0 && rvalid1)                   viol++;
      if (mem_en != (gnt0 || gnt1))             viol++;
      if (l3_gnt0 && l3_gnt1)                   viol++;
      if (l3_rvalid0 && l3_rvalid1)             viol++;
      if (l3_mem_en != (l3_gnt0 || l3_gnt1))    viol++;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   logic [31:0] shadow [0:255];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic init_shadow();
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      init_shadow();
      tick();
   endtask

   // One transaction on u_lat1, issued from IDLE; checks grant timing, RAM
   // command, read data/latency and that the other port stays quiet.
   task automatic run_txn(input bit port, input bit we, input logic [7:0] addr,
                          input logic [31:0] wdata, input string tag);
      int          n0, rv_off, rv_cnt, other_act;
      bit          got;
      logic [31:0] exp_rd, other_rd;
      exp_rd   = shadow[addr];
      other_rd = port ? rdata0 : rdata1;
      if (port) begin we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1; end
      else      begin we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1; end
      n0 = cyc;
      got = 1'b0;
      other_act = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (port ? gnt1 : gnt0) got = 1'b1;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check({tag, ":gnt_seen"}, 32'(got), 32'd1);
      check({tag, ":gnt_lat"}, 32'(cyc - n0), 32'd1);
      check({tag, ":mem_en"}, 32'(mem_en), 32'd1);
      check({tag, ":mem_we"}, 32'(mem_we), 32'(we));
      check({tag, ":mem_addr"}, 32'(mem_addr), 32'(addr));
      if (we) begin
         check({tag, ":mem_wdata"}, mem_wdata, wdata);
         shadow[addr] = wdata;
      end
      rv_off = -1;
      rv_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (port ? rvalid1 : rvalid0) begin
            rv_cnt++;
            if (rv_off < 0) rv_off = i;
            if (!we) check({tag, ":rdata"}, port ? rdata1 : rdata0, exp_rd);
         end
         if (port ? (gnt0 || rvalid0) : (gnt1 || rvalid1)) other_act++;
      end
      check({tag, ":rvalid_cnt"}, 32'(rv_cnt), we ? 32'd0 : 32'd1);
      if (!we) begin
         check({tag, ":rvalid_lat"}, 32'(rv_off), 32'd2);
         check({tag, ":rdata_hold"}, port ? rdata1 : rdata0, exp_rd);
      end
      check({tag, ":other_quiet"}, 32'(other_act), 32'd0);
      check({tag, ":other_rdata"}, port ? rdata0 : rdata1, other_rd);
   endtask

   task automatic wait_l3(input bit want_rv, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < 12 && !hit; i++) begin
         tick();
         if (want_rv ? l3_rvalid0 : l3_gnt0) hit = 1'b1;
      end
   endtask

   initial begin
      int   n0, ng, nrv, quiet, done_txn;
      int   order [4];
      bit   hit, got;
      bit   rd_out [2];
      logic [31:0] rd_exp [2];

      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      l3_req0 = 1'b0; l3_we0 = 1'b0; l3_addr0 = '0; l3_wdata0 = '0;
      init_shadow();

      // ---- reset state ----
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst:gnt0", 32'(gnt0), 32'd0);
      check("rst:gnt1", 32'(gnt1), 32'd0);
      check("rst:rvalid0", 32'(rvalid0), 32'd0);
      check("rst:rvalid1", 32'(rvalid1), 32'd0);
      check("rst:rdata0", rdata0, 32'd0);
      check("rst:mem_en", 32'(mem_en), 32'd0);
      check("rst:mem_addr", 32'(mem_addr), 32'd0);
      check("rst:l3_mem_en", 32'(l3_mem_en), 32'd0);

      // ---- single read on port 0 ----
      run_txn(1'b0, 1'b0, 8'h10, 32'h0, "t1_read0");
      check("t1:rdata0_val", rdata0, 32'hDEADBEEF);

      // ---- write then read on port 1 ----
      run_txn(1'b1, 1'b1, 8'h20, 32'h12345678, "t2_write1");
      run_txn(1'b1, 1'b0, 8'h20, 32'h0, "t2_read1");
      check("t2:rdata1_val", rdata1, 32'h12345678);

      // ---- latency sweep on the MEM_LAT=3 instance, req held ----
      l3_we0 = 1'b0; l3_addr0 = 8'h33; l3_req0 = 1'b1;
      n0 = cyc;
      wait_l3(1'b0, hit);
      check("t4:gnt_seen", 32'(hit), 32'd1);
      check("t4:gnt_lat", 32'(cyc - n0), 32'd1);
      wait_l3(1'b1, hit);
      check("t4:rv_seen", 32'(hit), 32'd1);
      check("t4:rv_lat", 32'(cyc - n0), 32'd5);
      check("t4:rdata", l3_rdata0, shadow[8'h33]);
      wait_l3(1'b0, hit);
      check("t4:gnt2_seen", 32'(hit), 32'd1);
      check("t4:gnt2_lat", 32'(cyc - n0), 32'd7);
      l3_req0 = 1'b0;
      wait_l3(1'b1, hit);
      check("t4:rv2_seen", 32'(hit), 32'd1);
      check("t4:rv2_lat", 32'(cyc - n0), 32'd11);
      check("t4:rdata2", l3_rdata0, shadow[8'h33]);

      // ---- tie after reset, then strict alternation ----
      pulse_reset();
      for (int i = 0; i < 4; i++) order[i] = -1;
      ng = 0;
      nrv = 0;
      we0 = 1'b0; addr0 = 8'h01; req0 = 1'b1;
      we1 = 1'b0; addr1 = 8'h02; req1 = 1'b1;
      for (int i = 0; i < 40 && nrv < 4; i++) begin
         tick();
         if (gnt0 || gnt1) begin
            if (ng < 4) order[ng] = gnt1 ? 1 : 0;
            ng++;
            if (ng == 4) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
         if (rvalid0) begin nrv++; check("t3:rdata0", rdata0, shadow[8'h01]); end
         if (rvalid1) begin nrv++; check("t3:rdata1", rdata1, shadow[8'h02]); end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("t3:order0", 32'(order[0]), 32'd0);
      check("t3:order1", 32'(order[1]), 32'd1);
      check("t3:order2", 32'(order[2]), 32'd0);
      check("t3:order3", 32'(order[3]), 32'd1);
      check("t3:grants", 32'(ng), 32'd4);
      check("t3:rvalids", 32'(nrv), 32'd4);
      tick();
      tick();

      // ---- reset during WAIT ----
      we1 = 1'b0; addr1 = 8'h10; req1 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (gnt1) got = 1'b1;
      end
      req1 = 1'b0;
      check("t5:gnt_seen", 32'(got), 32'd1);
      tick();                       // WAIT cycle
      reset = 1'b1;
      tick();
      check("t5:gnt1", 32'(gnt1), 32'd0);
      check("t5:rvalid1", 32'(rvalid1), 32'd0);
      check("t5:rdata1", rdata1, 32'd0);
      check("t5:mem_en", 32'(mem_en), 32'd0);
      check("t5:mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      init_shadow();
      quiet = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rvalid0 || rvalid1 || gnt0 || gnt1) quiet++;
      end
      check("t5:no_late_rvalid", 32'(quiet), 32'd0);
      run_txn(1'b1, 1'b0, 8'h10, 32'h0, "t5_reread1");

      // ---- random traffic with scoreboard ----
      done_txn = 0;
      rd_out[0] = 1'b0;
      rd_out[1] = 1'b0;
      rd_exp[0] = '0;
      rd_exp[1] = '0;
      for (int c = 0; c < 20000 && done_txn < 1000; c++) begin
         if (!req0 && $urandom_range(0, 3) != 0) begin
            we0 = ($urandom_range(0, 2) == 0);
            addr0 = 8'($urandom_range(0, 15));
            wdata0 = $urandom;
            req0 = 1'b1;
         end
         if (!req1 && $urandom_range(0, 3) != 0) begin
            we1 = ($urandom_range(0, 2) == 0);
            addr1 = 8'($urandom_range(0, 15));
            wdata1 = $urandom;
            req1 = 1'b1;
         end
         tick();
         if (gnt0) begin
            done_txn++;
            if (we0) shadow[addr0] = wdata0;
            else begin rd_out[0] = 1'b1; rd_exp[0] = shadow[addr0]; end
            req0 = 1'b0;
         end
         if (gnt1) begin
            done_txn++;
            if (we1) shadow[addr1] = wdata1;
            else begin rd_out[1] = 1'b1; rd_exp[1] = shadow[addr1]; end
            req1 = 1'b0;
         end
         if (rvalid0) begin
            check("t6:rv0_expected", 32'(rd_out[0]), 32'd1);
            check("t6:rdata0", rdata0, rd_exp[0]);
            rd_out[0] = 1'b0;
         end
         if (rvalid1) begin
            check("t6:rv1_expected", 32'(rd_out[1]), 32'd1);
            check("t6:rdata1", rdata1, rd_exp[1]);
            rd_out[1] = 1'b0;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (gnt0 || gnt1) done_txn++;
         if (rvalid0) begin
            check("t6:drain_rdata0", rdata0, rd_exp[0]);
            rd_out[0] = 1'b0;
         end
         if (rvalid1) begin
            check("t6:drain_rdata1", rdata1, rd_exp[1]);
            rd_out[1] = 1'b0;
         end
      end
      check("t6:txn_count_reached", 32'(done_txn >= 1000), 32'd1);
      check("t6:rd0_drained", 32'(rd_out[0]), 32'd0);
      check("t6:rd1_drained", 32'(rd_out[1]), 32'd0);

      // ---- global invariants ----
      check("mon:violations", 32'(viol), 32'd0);
      check("l3:port1_rdata", l3_rdata1, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
